// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: 8N1 UART endpoint pairing received bytes into 16-bit commands and sending response bytes
module uart_cmd_wrapper #(
  parameter int          BAUD_DIV = 2604,
  parameter logic [21:0] TIMEOUT  = 22'd2_600_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        frm_err
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} pair_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
  rx_state_t rx_state, rx_nxt;
  pair_state_t pair_state, pair_nxt;
  tx_state_t tx_state, tx_nxt;
  logic rx_ff1, rx_sync;
  logic [BW-1:0] rx_baud, tx_baud;
  logic [3:0] rx_bits, tx_bits;
  logic [7:0] rx_data, hi;
  logic [21:0] to_cnt;
  logic [9:0] tx_shift;
  logic rx_tick, rx_start, rx_last, rx_vld, rx_err, to_exp, lo_done, tx_load, tx_tick;
  // Preset high so reset release never looks like a start bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_sync <= rx_ff1;
    end
  assign rx_tick  = rx_state == RX_RECV && rx_baud == '0;
  assign rx_start = rx_state == RX_IDLE && !rx_sync;
  assign rx_last  = rx_tick && rx_bits == 4'd9;
  assign rx_vld   = rx_last && rx_sync;
  assign rx_err   = rx_last && !rx_sync;
  always_comb
    rx_nxt = rx_start ? RX_RECV :
             (rx_last || (rx_tick && rx_bits == 4'd0 && rx_sync)) ? RX_IDLE : rx_state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_data  <= '0;
      frm_err  <= 1'b0;
    end else begin
      rx_state <= rx_nxt;
      frm_err  <= rx_err;
      if (rx_start) begin
        rx_baud <= BAUD_HALF;
        rx_bits <= '0;
      end else if (rx_tick) begin
        rx_baud <= BAUD_LAST;
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits != 4'd0 && rx_bits != 4'd9) rx_data <= {rx_sync, rx_data[7:1]};
      end else if (rx_state == RX_RECV) rx_baud <= rx_baud - BW'(1);
    end
  // The low-byte window only counts while the receiver is idle
  assign to_exp  = pair_state == WAIT_LO && rx_state == RX_IDLE && to_cnt == TIMEOUT;
  assign lo_done = rx_vld && pair_state == WAIT_LO;
  always_comb
    pair_nxt = rx_vld ? (pair_state == WAIT_HI ? WAIT_LO : WAIT_HI) :
               (rx_err || to_exp) ? WAIT_HI : pair_state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pair_state <= WAIT_HI;
      hi         <= '0;
      to_cnt     <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      pair_state <= pair_nxt;
      if (rx_vld && pair_state == WAIT_HI) begin
        hi     <= rx_data;
        to_cnt <= '0;
      end else if (pair_state == WAIT_LO && rx_state == RX_IDLE && !to_exp) to_cnt <= to_cnt + 22'd1;
      if (lo_done) cmd <= {hi, rx_data};
      cmd_rdy <= lo_done || (cmd_rdy && !clr_cmd_rdy && !(rx_start && pair_state == WAIT_HI));
    end
  // TX is the shift register's LSB, which idles and refills with ones
  assign TX      = tx_shift[0];
  assign tx_load = tx_state == TX_IDLE && trmt;
  assign tx_tick = tx_state == TX_XMIT && tx_baud == BAUD_LAST;
  always_comb
    tx_nxt = tx_load ? TX_XMIT : (tx_tick && tx_bits == 4'd9) ? TX_IDLE : tx_state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_nxt;
      if (tx_load) begin
        tx_shift <= {1'b1, resp, 1'b0};
        tx_baud  <= '0;
        tx_bits  <= '0;
        tx_done  <= 1'b0;
      end else if (tx_tick) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_baud  <= '0;
        tx_bits  <= tx_bits + 4'd1;
        if (tx_bits == 4'd9) tx_done <= 1'b1;
      end else if (tx_state == TX_XMIT) tx_baud <= tx_baud + BW'(1);
    end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: directed and randomized checks of the UART command endpoint against a byte-level model
module tb_uart_cmd_wrapper;
  localparam int BIT = 16;
  localparam int TMO = 2000;
  logic clk = 1'b0, rst = 1'b1, RX = 1'b1, clr_cmd_rdy = 1'b0, trmt = 1'b0;
  logic [7:0] resp = '0;
  logic TX, cmd_rdy, tx_done, frm_err;
  logic [15:0] cmd;
  int tests = 0, errors = 0;
  logic m_have_hi = 1'b0, m_rdy = 1'b0;
  logic [7:0] m_hi = '0;
  logic [15:0] m_cmd = '0;
  uart_cmd_wrapper #(.BAUD_DIV(BIT), .TIMEOUT(22'd2000)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done), .frm_err(frm_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Drives one frame; with hold_clr, clr_cmd_rdy is high through the stop bit until cmd_rdy appears
  task automatic send_byte(input logic [7:0] b, input bit ok, input bit hold_clr, output int errs);
    logic [9:0] f;
    f = {ok, b, 1'b0};
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      RX = f[k];
      if (k == 9) clr_cmd_rdy = hold_clr;
      repeat (BIT) begin
        @(negedge clk);
        errs += int'(frm_err);
        if (clr_cmd_rdy && cmd_rdy) clr_cmd_rdy = 1'b0;
      end
    end
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
  endtask
  task automatic rx_byte(input logic [7:0] b, input bit ok, input int gap, input bit hold_clr);
    int errs;
    repeat (gap) @(negedge clk);
    send_byte(b, ok, hold_clr, errs);
    if (!m_have_hi || gap > TMO) begin
      m_rdy = 1'b0;
      m_have_hi = ok;
      m_hi = b;
    end else begin
      m_have_hi = 1'b0;
      if (ok) begin
        m_cmd = {m_hi, b};
        m_rdy = 1'b1;
      end
    end
    check("frm_err_pulses", errs, ok ? 0 : 1);
    check("cmd", cmd, m_cmd);
    check("cmd_rdy", cmd_rdy, m_rdy);
  endtask
  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    check("clr_cmd_rdy", cmd_rdy, m_rdy);
  endtask
  task automatic tx_frame(input logic [7:0] b, input bit second);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    resp = b;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    for (int k = 0; k < 10 * BIT; k++) begin
      if (k % BIT == 0 || k % BIT == BIT - 1) begin
        check("tx_bit", TX, f[k / BIT]);
        check("tx_done_busy", tx_done, 0);
      end
      if (second && k == 40) begin
        resp = ~b;
        trmt = 1'b1;
      end
      if (k == 41) trmt = 1'b0;
      @(negedge clk);
    end
    check("tx_done_end", tx_done, 1);
    check("tx_idle", TX, 1);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_TX", TX, 1);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_frm_err", frm_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rx_byte(8'h2F, 1, 5, 0);
    rx_byte(8'h00, 1, 3, 0);
    pulse_clr();
    tx_frame(8'hA5, 1);
    rx_byte(8'h41, 1, 5, 0);
    rx_byte(8'h01, 1, 2500, 0);
    rx_byte(8'h23, 1, 4, 0);
    rx_byte(8'h77, 1, 5, 0);
    rx_byte(8'h99, 0, 5, 0);
    rx_byte(8'h4C, 1, 30, 0);
    rx_byte(8'h12, 1, 5, 0);
    rx_byte(8'h33, 1, 10, 0);
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    repeat (40) @(negedge clk);
    check("tx_mid_frame", TX, 0);
    #2 rst = 1'b1;
    RX = 1'b1;
    #1;
    check("arst_TX", TX, 1);
    check("arst_cmd_rdy", cmd_rdy, 0);
    check("arst_tx_done", tx_done, 0);
    check("arst_cmd", cmd, 0);
    @(negedge clk);
    rst = 1'b0;
    m_have_hi = 1'b0;
    m_rdy = 1'b0;
    m_cmd = '0;
    rx_byte(8'h20, 1, 5, 0);
    rx_byte(8'h11, 1, 5, 0);
    fork
      begin
        rx_byte(8'h5A, 1, 0, 0);
        rx_byte(8'hC3, 1, 3, 1);
      end
      begin
        repeat (20) @(negedge clk);
        tx_frame(8'h5A, 0);
      end
    join
    fork
      begin
        bit prev_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
          bit ok;
          int gap;
          ok = $urandom_range(0, 7) != 0;
          gap = ($urandom_range(0, 7) == 0) ? 2100 + int'($urandom_range(0, 200)) : int'($urandom_range(0, 40));
          if (!prev_ok && gap < 20) gap = 20;
          rx_byte(8'($urandom), ok, gap, 1'($urandom_range(0, 1)));
          prev_ok = ok;
          if ($urandom_range(0, 3) == 0) pulse_clr();
        end
      end
      begin
        repeat (6) begin
          repeat ($urandom_range(0, 30)) @(negedge clk);
          tx_frame(8'($urandom), 1'($urandom_range(0, 1)));
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Robot-side endpoint of the BLE/UART command link. It is the responder to the remote commander, which sends 16-bit commands as two 8N1 bytes and expects 8-bit responses.
- Contains an 8N1 receiver, an 8N1 transmitter, and a byte-pairing FSM. The FSM assembles the high byte then the low byte into a 16-bit cmd for the command processor.
- Sends single response bytes (e.g. 0xA5 "complete") back on TX.

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); minimum 8.
- TIMEOUT, 22'd2_600_000, clocks allowed between the end of the high byte and the start bit of the low byte before the high byte is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- RX  in  1  serial input from the remote transmitter; asynchronous, idle high
- TX  out  1  serial output to the remote receiver; idle high
- cmd  out  16  assembled command, {high byte, low byte}
- cmd_rdy  out  1  held high while cmd is valid
- clr_cmd_rdy  in  1  consumer knocks down cmd_rdy
- resp  in  8  response byte to send
- trmt  in  1  one-cycle pulse to start sending resp
- tx_done  out  1  high from the end of a frame until the next accepted trmt
- frm_err  out  1  one-cycle pulse when a received stop bit is 0

Behaviour:
- Reset values:
  - TX=1, cmd=0, cmd_rdy=0, tx_done=0, frm_err=0.
  - RX synchronizer flops preset to 1, so no false start bit is seen.
  - All FSMs in IDLE; all counters 0.
- Reset asserted mid-frame (rx or tx) aborts immediately. TX returns to 1 asynchronously. A partial byte is lost and a held high byte is discarded.
- RX path, 2-flop synchronizer:
  - IDLE: wait for synchronized RX = 0, then go to RECV and load baud_cnt = BAUD_DIV/2.
  - RECV: on each baud_cnt expiry, sample and reload BAUD_DIV. Take 10 samples: start, d0..d7 (LSB first), stop.
  - After the 10th sample, return to IDLE. Stop = 1 produces a one-cycle rx_byte_vld. Stop = 0 produces a frm_err pulse and the byte is discarded.
  - A start sample that reads 1 (glitch) returns to IDLE with no byte and no frm_err.
- Pairing FSM:
  - WAIT_HI: a valid byte is stored as the high byte; go to WAIT_LO and clear the timeout counter.
  - WAIT_LO: the timeout counter runs until RX enters RECV. If the counter reaches TIMEOUT first, discard the high byte and go to WAIT_HI.
  - WAIT_LO, valid byte received: cmd <= {hi, byte}; cmd_rdy set the next cycle; go to WAIT_HI.
  - WAIT_LO, frm_err: discard the high byte and go to WAIT_HI.
  - cmd changes only on low-byte completion.
- cmd_rdy:
  - Cleared by clr_cmd_rdy.
  - Also cleared when a start bit of a new high byte is detected.
  - If a set and a clear occur in the same cycle, the set wins.
- Latency: cmd_rdy rises 1 clk after the low byte's stop-bit sample.
- TX path:
  - IDLE: TX=1. trmt latches resp into a 10-bit shift register {1, resp, 0}, clears tx_done, and goes to XMIT.
  - XMIT: shift one bit every BAUD_DIV clocks, LSB first. After 10 bit-times, go to IDLE and set tx_done.
  - Total frame length: exactly 10*BAUD_DIV clocks from trmt to tx_done.
  - trmt while in XMIT is ignored; the frame is not corrupted and tx_done stays 0.
  - TX is registered (glitch-free).
- RX and TX operate independently; full duplex is supported.

Test Plan:
- Sim with BAUD_DIV=16, TIMEOUT=2000.
- Remote sends 0x2F then 0x00 (calibrate):
  - cmd_rdy rises 1 clk after the second stop-bit sample; cmd=16'h2F00.
  - clr_cmd_rdy pulse drops cmd_rdy the next cycle.
- trmt with resp=0xA5:
  - TX shows 0,1,0,1,0,0,1,0,1,1, each bit held 16 clks.
  - tx_done rises at clk 160.
  - A second trmt at clk 40 is ignored.
- High byte 0x41, then idle 2500 clks, then 0x01 and 0x23:
  - No cmd_rdy after 0x41/0x01 (timeout discards 0x41).
  - cmd=16'h0123 with cmd_rdy=1.
- Frame with stop bit forced to 0 as the low byte:
  - frm_err pulses one cycle; cmd_rdy stays 0; cmd is unchanged.
  - The next good pair 0x4C,0x12 gives cmd=16'h4C12.
- Assert rst mid-way through the low byte and mid-way through a TX frame:
  - TX=1 immediately; cmd_rdy=0; tx_done=0.
  - Post-reset pair 0x20,0x11 yields cmd=16'h2011.
- Simultaneous RX of 0x5A,0xC3 and TX of 0x5A:
  - Both complete correctly.
  - A clr_cmd_rdy coincident with the low-byte completion leaves cmd_rdy=1.
